// File: rtl/downscale_average_pkg.sv
// downscale_average_pkg: shared state encoding, widths and fator constants for the scaler blocks
package downscale_average_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, WRITE, DONE} state_t;
    localparam int ADDR_W = 19;
    localparam int PIX_W = 8;
    localparam int ACC_W = 12;
    localparam logic [2:0] FATOR_1 = 3'd1;
    localparam logic [2:0] FATOR_2 = 3'd2;
    localparam logic [2:0] FATOR_4 = 3'd4;
    function automatic logic fator_ok(input logic [2:0] f);
        return f == FATOR_1 || f == FATOR_2 || f == FATOR_4;
    endfunction
    function automatic logic [1:0] sh_of(input logic [2:0] f);
        return f == FATOR_4 ? 2'd2 : f == FATOR_2 ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/downscale_average_if.sv
// downscale_average_if: control, ROM read and RAM write signals of the scaler
interface downscale_average_if;
    import downscale_average_pkg::*;
    logic start;
    logic [2:0] fator;
    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0] rom_data;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [PIX_W-1:0] ram_data;
    logic ram_wren;
    logic busy;
    logic done;
    logic erro;
    modport master(
        input start, fator, rom_data,
        output rom_addr, ram_wraddr, ram_data, ram_wren, busy, done, erro
    );
    modport slave(
        output start, fator, rom_data,
        input rom_addr, ram_wraddr, ram_data, ram_wren, busy, done, erro
    );
endinterface

// File: rtl/downscale_average_addr_gen.sv
// downscale_addr_gen: block/intra-block counters plus source and destination address math
module downscale_addr_gen
    import downscale_average_pkg::*;
#(
    parameter int LARGURA = 160,
    parameter int ALTURA = 120
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic step,
    input  logic advance,
    input  logic [1:0] sh,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic blk_end,
    output logic frame_end
);
    logic [ADDR_W-1:0] bx, by, nl, nh;
    logic [2:0] di, dj, fm1;
    logic last_x;
    assign fm1 = (3'd1 << sh) - 3'd1;
    assign nl = ADDR_W'(LARGURA) >> sh;
    assign nh = ADDR_W'(ALTURA) >> sh;
    assign last_x = bx == nl - 1'b1;
    assign blk_end = dj == fm1 && di == fm1;
    assign frame_end = last_x && by == nh - 1'b1;
    assign rd_addr = ((by << sh) + ADDR_W'(di)) * ADDR_W'(LARGURA) + (bx << sh) + ADDR_W'(dj);
    assign wr_addr = by * nl + bx;
    // dj/di walk the F x F block while reading; bx/by move to the next block on each write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {bx, by, di, dj} <= '0;
        end else if (clear) begin
            {bx, by, di, dj} <= '0;
        end else if (step) begin
            dj <= dj == fm1 ? 3'd0 : dj + 3'd1;
            if (dj == fm1) di <= di == fm1 ? 3'd0 : di + 3'd1;
        end else if (advance) begin
            bx <= last_x ? '0 : bx + 1'b1;
            if (last_x) by <= by + 1'b1;
        end
    end
endmodule

// File: rtl/downscale_average.sv
// downscale_average: box-filter decimation by 1/2/4; define DOWNSCALE_ROUND_EN for round-half-up output
module downscale_average
    import downscale_average_pkg::*;
#(
    parameter int LARGURA = 160,
    parameter int ALTURA = 120
) (
    input logic clk,
    input logic reset,
    downscale_average_if.master bus
);
    state_t state, state_nxt;
    logic [2:0] f;
    logic [1:0] sh;
    logic [ACC_W-1:0] acc, sum;
    logic [ADDR_W-1:0] addr_hold, rd_addr, wr_addr;
    logic rd_valid, erro, blk_end, frame_end, go;
    downscale_addr_gen #(.LARGURA(LARGURA), .ALTURA(ALTURA)) u_addr (
        .clk(clk),
        .reset(reset),
        .clear(state == LOAD),
        .step(state == READ),
        .advance(state == WRITE),
        .sh(sh),
        .rd_addr(rd_addr),
        .wr_addr(wr_addr),
        .blk_end(blk_end),
        .frame_end(frame_end)
    );
    assign go = bus.start && (state == IDLE || state == DONE);
`ifdef DOWNSCALE_ROUND_EN
    assign sum = acc + ((ACC_W'(f) * ACC_W'(f)) >> 1);
`else
    assign sum = acc;
`endif
    assign bus.busy = state inside {LOAD, READ, DRAIN, WRITE};
    assign bus.done = state == DONE;
    assign bus.erro = erro;
    assign bus.ram_wren = state == WRITE;
    assign bus.ram_wraddr = state == WRITE ? wr_addr : '0;
    assign bus.ram_data = state == WRITE ? PIX_W'(sum >> {sh, 1'b0}) : '0;
    assign bus.rom_addr = state == READ ? rd_addr : addr_hold;
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end
    // next-state: read F*F samples, drain the ROM latency, write one pixel
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = go ? LOAD : state;
            LOAD: state_nxt = fator_ok(f) ? READ : DONE;
            READ: state_nxt = blk_end ? DRAIN : READ;
            DRAIN: state_nxt = WRITE;
            WRITE: state_nxt = frame_end ? DONE : READ;
            default: state_nxt = IDLE;
        endcase
    end
    // fator latch, error flag, held ROM address and accumulation of data arriving one cycle after each read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {f, sh, erro, acc, rd_valid, addr_hold} <= '0;
        end else begin
            rd_valid <= state == READ;
            if (go) begin
                f <= bus.fator;
                erro <= 1'b0;
            end
            if (state == LOAD) begin
                sh <= sh_of(f);
                erro <= !fator_ok(f);
            end
            if (state == READ) addr_hold <= rd_addr;
            acc <= (state == LOAD || state == WRITE) ? '0 : rd_valid ? acc + ACC_W'(bus.rom_data) : acc;
        end
    end
endmodule

// File: tb/tb_downscale_average.sv
// tb_downscale_average: directed frames at reduced 48x32 geometry with hand-computed results
module tb_downscale_average;
    import downscale_average_pkg::*;
    localparam int W = 48;
    localparam int H = 32;
    localparam int LIMIT = 20000;
`ifdef DOWNSCALE_ROUND_EN
    localparam int AVG = 12;
`else
    localparam int AVG = 11;
`endif
    logic clk = 1'b0;
    logic reset;
    int n_vec = 0, n_err = 0, mode = 0, wcount = 0, last_wa = 0, data_err = 0, seq_err = 0;
    int n, snap;
    downscale_average_if bus();
    downscale_average #(.LARGURA(W), .ALTURA(H)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [18:0] a);
        int ai = int'(a);
        return mode == 0 ? 8'(ai) : mode == 1 ? 8'(10 + 2 * ((ai / W) % 2) + (ai % W) % 2) : 8'd255;
    endfunction

    function automatic int exp_data(input logic [18:0] wa);
        return mode == 0 ? int'(wa[7:0]) : mode == 1 ? AVG : 255;
    endfunction

    // synchronous ROM: data one cycle after the address
    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

    // write monitor: data and in-order destination addresses
    always @(negedge clk) begin
        if (bus.ram_wren) begin
            if (int'(bus.ram_data) != exp_data(bus.ram_wraddr)) data_err++;
            if (int'(bus.ram_wraddr) != wcount) seq_err++;
            last_wa = int'(bus.ram_wraddr);
            wcount++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic [2:0] f, input int m);
        mode = m;
        wcount = 0;
        data_err = 0;
        seq_err = 0;
        @(negedge clk);
        bus.fator = f;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!bus.done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_writes(input int k);
        int t = 0;
        while (wcount < k && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        check("reach_writes", int'(wcount >= k), 1);
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;
        bus.fator = 3'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_erro", bus.erro, 0);
        check("rst_wren", bus.ram_wren, 0);
        check("rst_rom_addr", int'(bus.rom_addr), 0);
        check("rst_wraddr", int'(bus.ram_wraddr), 0);
        reset = 1'b1;

        start_frame(3'd1, 0);
        wait_done(n);
        check("f1_cycles", n, 4610);
        check("f1_writes", wcount, 1536);
        check("f1_data", data_err, 0);
        check("f1_seq", seq_err, 0);
        check("f1_erro", bus.erro, 0);
        repeat (5) @(negedge clk);
        check("done_hold", bus.done, 1);
        check("done_busy", bus.busy, 0);

        start_frame(3'd2, 1);
        wait_done(n);
        check("f2_cycles", n, 2306);
        check("f2_writes", wcount, 384);
        check("f2_last", last_wa, 383);
        check("f2_data", data_err, 0);
        check("f2_seq", seq_err, 0);

        start_frame(3'd4, 2);
        wait_done(n);
        check("f4_cycles", n, 1730);
        check("f4_writes", wcount, 96);
        check("f4_last", last_wa, 95);
        check("f4_data", data_err, 0);

        start_frame(3'd3, 0);
        wait_done(n);
        check("f3_cycles", n, 2);
        check("f3_erro", bus.erro, 1);
        check("f3_done", bus.done, 1);
        repeat (3) @(negedge clk);
        check("f3_writes", wcount, 0);

        start_frame(3'd0, 0);
        wait_done(n);
        check("f0_cycles", n, 2);
        check("f0_erro", bus.erro, 1);
        repeat (3) @(negedge clk);
        check("f0_writes", wcount, 0);

        start_frame(3'd2, 1);
        wait_writes(10);
        @(negedge clk);
        bus.fator = 3'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        check("ms_writes", wcount, 384);
        check("ms_last", last_wa, 383);
        check("ms_data", data_err, 0);
        check("ms_seq", seq_err, 0);
        check("ms_erro", bus.erro, 0);

        start_frame(3'd2, 1);
        wait_writes(100);
        reset = 1'b0;
        #1;
        check("ar_wren", bus.ram_wren, 0);
        check("ar_busy", bus.busy, 0);
        check("ar_done", bus.done, 0);
        check("ar_data", int'(bus.ram_data), 0);
        check("ar_wraddr", int'(bus.ram_wraddr), 0);
        check("ar_rom_addr", int'(bus.rom_addr), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        snap = wcount;
        repeat (20) @(negedge clk);
        check("ar_no_write", wcount, snap);
        check("ar_idle", bus.busy, 0);
        start_frame(3'd2, 1);
        wait_done(n);
        check("ar_cycles", n, 2306);
        check("ar_writes", wcount, 384);
        check("ar_seq", seq_err, 0);
        check("ar_data2", data_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/downscale_average.md
DOWNSCALE_AVERAGE -- requirements
Module: downscale_average

Interface
REQ-001 Parameters: LARGURA, default 160, source width in pixels; ALTURA, default 120, source height in pixels.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low; clock clk.
REQ-004 start  input  1  one-cycle pulse; begins a frame when sampled in IDLE or DONE.
REQ-005 fator  input  3  decimation factor; valid values are 1, 2 and 4.
REQ-006 rom_addr  output  19  source pixel address; ROM returns rom_data one cycle later.
REQ-007 rom_data  input  8  source grey pixel.
REQ-008 ram_wraddr  output  19  destination pixel address.
REQ-009 ram_data  output  8  averaged destination pixel.
REQ-010 ram_wren  output  1  destination write strobe, one cycle per destination pixel.
REQ-011 busy, done, erro  output  1 each  frame in progress, frame complete, invalid fator.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, READ, DRAIN, WRITE and DONE.
REQ-013 On start in IDLE or DONE, the block SHALL latch fator to F, clear done and erro, and enter LOAD.
REQ-014 In LOAD, for F not in {1,2,4}, it SHALL set erro=1 and done=1, enter DONE and issue no ram_wren.
REQ-015 In LOAD, for valid F, it SHALL compute SH=log2(F) and NL=LARGURA>>SH, clear all counters and the accumulator, and enter READ.
REQ-016 In READ, it SHALL issue one rom_addr per cycle: (by*F+di)*LARGURA + (bx*F+dj).
- dj is the inner counter, then di; both run 0..F-1.
REQ-017 The accumulator SHALL add rom_data in the cycle after each address issue, reaching exactly F*F samples per block.
- Accumulator width: 12 bits (max 16*255 = 4080, no overflow).
REQ-018 After the last address of a block, the FSM SHALL go to DRAIN for one cycle to absorb the final sample, then to WRITE.
REQ-019 In WRITE, for exactly one cycle, it SHALL drive ram_wren=1, ram_wraddr=by*NL+bx and ram_data=acc>>(2*SH), then clear the accumulator.
REQ-020 Block sequencing after WRITE: bx increments up to NL-1, then wraps to 0 with by+1.
- Last block is by=(ALTURA>>SH)-1, bx=NL-1; WRITE then goes to DONE, otherwise back to READ.
REQ-021 Block cost SHALL be F*F+2 cycles, e.g. 28800 cycles per frame for F=2 with default parameters.
REQ-022 In DONE, done SHALL remain 1 and busy 0 until the next start.
- busy=1 in LOAD, READ, DRAIN and WRITE.
REQ-023 A start pulse while busy=1 SHALL be ignored.
- A change of fator mid-frame SHALL have no effect; F is latched.
REQ-024 ram_wren SHALL be 0 in every state except WRITE.
- rom_addr SHALL hold its last value outside READ.

Reset
REQ-025 On reset low, the block SHALL enter IDLE asynchronously.
- Cleared: rom_addr, ram_wraddr, ram_data, ram_wren, busy, done, erro, all counters, the accumulator and F.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no further writes; a new start is required after release.

Configuration
REQ-027 Macro DOWNSCALE_ROUND_EN, when defined, SHALL give ram_data=(acc+((F*F)>>1))>>(2*SH), rounding half up.
- When undefined, ram_data SHALL truncate.
- For F=1 both modes are identical.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the 19-bit address width, the 8-bit pixel width and the valid-fator constants 1, 2 and 4.
- The upscale block SHALL use the same package.
REQ-029 One sub-module, downscale_addr_gen, SHALL hold the bx/by/di/dj counters and both address computations.
- The top level SHALL hold the FSM, accumulator and divider shift.

Verification
REQ-030 fator=1, ROM pattern addr[7:0], start -> 19200 writes, ram_data==ROM at equal address, done after 57600+2 cycles.
REQ-031 fator=2, ROM block values 10,11,12,13 -> ram_data=11 truncating, 12 with DOWNSCALE_ROUND_EN; 4800 writes, last ram_wraddr=4799.
REQ-032 fator=4, all ROM=255 -> 1200 writes of 255 with no accumulator overflow; last ram_wraddr=1199.
REQ-033 fator=3 (then 0) with start -> erro=1 and done=1 within 2 cycles; ram_wren never asserted.
REQ-034 reset pulsed low at write 100 of an F=2 frame -> all outputs 0 immediately; no ram_wren until a new start.
- New frame restarts at ram_wraddr=0.
REQ-035 start re-pulsed mid-frame with fator changed to 4 -> ignored; the frame completes with 4800 writes at F=2.
